alu_share_arb: RTL
==================

Name: alu_share_arb

Overview:
Round-robin arbiter/sequencer that time-shares one 32-bit integer ALU among N_REQ requesters, e.g. the main execute stage, the branch-target adder and a debug/test port. Each request carries two operands and a 4-bit ALU control code. The block owns the single ALU instance, registers the operands, captures the result and flags, and returns them to the winning requester over a valid/ready handshake. It is a multi-cycle, one-op-in-flight unit.

Parameters:
N_REQ, 2, number of requesters (2..8)
PTR_W, $clog2(N_REQ) (min 1), width of the grant/owner index (derived, not overridden)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  reset, asynchronous assert, active-low
i_req_valid  input  N_REQ  per-requester request valid
i_req_op1  input  N_REQ*32  packed operand 1; requester k uses bits [32k+31:32k]
i_req_op2  input  N_REQ*32  packed operand 2, same packing
i_req_ctrl  input  N_REQ*4  packed ALU control; requester k uses bits [4k+3:4k]
o_req_ready  output  N_REQ  one-hot accept strobe (combinational)
o_rsp_valid  output  N_REQ  one-hot response valid, registered
i_rsp_ready  input  N_REQ  per-requester response accept
o_rsp_result  output  32  result of the served op
o_rsp_overflow  output  1  ALU overflow flag of the served op
o_rsp_zf  output  1  ALU zero flag (result == 0)
o_busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (i_rst_n low, asynchronous): state=IDLE, rr_ptr=0, owner=0, operand/ctrl regs=0, o_rsp_valid=0, o_rsp_result=0, o_rsp_overflow=0, o_rsp_zf=0, o_busy=0. Reset mid-operation discards the in-flight op with no response.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: winner = first k with i_req_valid[k]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ. o_req_ready[winner]=1 in the same cycle, all other bits 0. No valid requests: o_req_ready=0 and the FSM stays in IDLE. On the edge, latch op1/op2/ctrl and owner=winner, then go to EXEC.
- o_req_ready is 0 in EXEC and RESP. Requesters hold their valid and data until they see ready.
- EXEC: the ALU is driven only from the latched registers. On the edge, capture result/overflow/zf into the o_rsp_* registers, set o_rsp_valid[owner]=1, go to RESP.
- RESP: o_rsp_valid[owner] and the data stay stable until i_rsp_ready[owner]=1. On that edge: clear o_rsp_valid, set rr_ptr=(owner+1) mod N_REQ, go to IDLE. i_rsp_ready of non-owners is ignored.
- Latency: accept edge T; o_rsp_valid is high from T+2. Best-case throughput is one op per 3 cycles with i_rsp_ready tied high.
- ALU codes: ADD=0000 (overflow = carry-out bit 32), ADDU=0001, SUB=0010, AND=0100, OR=0101, NOR=0110, LUI=1001 (op2[15:0]<<16), SLT=1010 (unsigned compare, result 0/1). Any other code gives result 0 and zf=1. Overflow is 0 for all non-ADD codes.
- A requester that drops valid in IDLE before being granted is simply not served; there is no error.
- A new request from the current owner while in RESP waits for the next IDLE; rr_ptr has already moved past it.
- Starvation bound: any continuously asserted request is granted within N_REQ arbitration rounds.

Decomposition:
- Shared package alu_pkg: the ALU control localparams (ADD, ADDU, SUB, AND, OR, NOR, SLT, LUI), the 32-bit data width constant, and the state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
- One sub-module: rr_pick, a combinational round-robin priority picker (inputs: valid vector, rr_ptr; outputs: one-hot grant, index).
- The existing ALU is instantiated once, inside this block.

Test Plan:
- Single ADD: req0 op1=0xFFFFFFFF, op2=0x1, ctrl=0000, rsp_ready=1 -> o_rsp_valid[0] at T+2 with result 0x00000000, overflow=1, zf=1.
- Contention: req0 and req1 valid together at reset, both SUB 10-3 -> req0 served first (result 7), then req1 at accept T+3 (+3 cycles); rr_ptr alternates across 4 back-to-back ops.
- Backpressure: req1 LUI op2=0x1234, i_rsp_ready[1]=0 for 5 cycles -> result 0x12340000 held stable, o_busy=1, o_req_ready=0 throughout; released on the ready edge.
- SLT/NOR/illegal codes: SLT 3,5 -> 1; NOR 0,0 -> 0xFFFFFFFF; ctrl=1111 -> result 0, zf=1, overflow=0.
- Async reset in EXEC: assert i_rst_n=0 mid-cycle -> all outputs 0 immediately; after release, next request is served by requester 0 first.
- Fairness, N_REQ=4 with all requesters always valid -> grant order 0,1,2,3,0 and no requester waits more than 4 grants.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, data width, sequencer state encoding
// and the combinational ALU evaluated once inside the arbiter.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDU = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              overflow;
    logic              zf;
  } alu_out_t;

  function automatic alu_out_t alu_eval(input logic [DATA_W-1:0] op1,
                                        input logic [DATA_W-1:0] op2,
                                        input logic [3:0]        ctrl);
    alu_out_t         res;
    logic [DATA_W:0]  sum;
    res = '0;
    sum = {1'b0, op1} + {1'b0, op2};
    case (ctrl)
      // Only signed-style ADD reports overflow, and it is the raw carry-out.
      ALU_ADD: begin
        res.result   = sum[DATA_W-1:0];
        res.overflow = sum[DATA_W];
      end
      ALU_ADDU: res.result = sum[DATA_W-1:0];
      ALU_SUB:  res.result = op1 - op2;
      ALU_AND:  res.result = op1 & op2;
      ALU_OR:   res.result = op1 | op2;
      ALU_NOR:  res.result = ~(op1 | op2);
      ALU_LUI:  res.result = {op2[15:0], 16'h0000};
      ALU_SLT:  res.result = (op1 < op2) ? DATA_W'(1) : '0;
      default:  res.result = '0;
    endcase
    res.zf = (res.result == '0);
    return res;
  endfunction

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] rot_idx [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    logic [PTR_W:0] sum;
    assign sum = {1'b0, ptr} + (PTR_W+1)'(gi);
    assign rot_idx[gi] = (sum >= (PTR_W+1)'(N_REQ)) ? PTR_W'(sum - (PTR_W+1)'(N_REQ))
                                                    : sum[PTR_W-1:0];
  end

  // Scan from the farthest offset down so the nearest valid one wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (valid[rot_idx[i]]) begin
        grant             = '0;
        grant[rot_idx[i]] = 1'b1;
        idx               = rot_idx[i];
        any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one 32-bit ALU among N_REQ requesters: round-robin accept,
// one op in flight, registered response held until the owner accepts it.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [N_REQ*DATA_W-1:0] i_req_op1,
  input  logic [N_REQ*DATA_W-1:0] i_req_op2,
  input  logic [N_REQ*4-1:0]      i_req_ctrl,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic [N_REQ-1:0]        o_rsp_valid,
  input  logic [N_REQ-1:0]        i_rsp_ready,
  output logic [DATA_W-1:0]       o_rsp_result,
  output logic                    o_rsp_overflow,
  output logic                    o_rsp_zf,
  output logic                    o_busy
);

  logic [1:0]        state_reg;
  logic [PTR_W-1:0]  rr_ptr_reg;
  logic [PTR_W-1:0]  owner_reg;
  logic [DATA_W-1:0] op1_reg;
  logic [DATA_W-1:0] op2_reg;
  logic [3:0]        ctrl_reg;
  logic [N_REQ-1:0]  rsp_valid_reg;
  logic [DATA_W-1:0] result_reg;
  logic              overflow_reg;
  logic              zf_reg;

  logic [DATA_W-1:0] op1_arr  [N_REQ];
  logic [DATA_W-1:0] op2_arr  [N_REQ];
  logic [3:0]        ctrl_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign op1_arr[gi]  = i_req_op1[DATA_W*gi +: DATA_W];
    assign op2_arr[gi]  = i_req_op2[DATA_W*gi +: DATA_W];
    assign ctrl_arr[gi] = i_req_ctrl[4*gi +: 4];
  end

  logic [N_REQ-1:0] pick_grant;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .valid (i_req_valid),
    .ptr   (rr_ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The single ALU sees only latched operands, never the live request buses.
  alu_out_t alu_out;
  assign alu_out = alu_eval(op1_reg, op2_reg, ctrl_reg);

  logic [PTR_W-1:0] ptr_after_owner;
  assign ptr_after_owner = (owner_reg == PTR_W'(N_REQ - 1)) ? '0 : owner_reg + PTR_W'(1);

  // Ready is masked during reset so no accept strobe appears while held in reset.
  assign o_req_ready    = (state_reg == ST_IDLE && i_rst_n) ? pick_grant : '0;
  assign o_rsp_valid    = rsp_valid_reg;
  assign o_rsp_result   = result_reg;
  assign o_rsp_overflow = overflow_reg;
  assign o_rsp_zf       = zf_reg;
  assign o_busy         = (state_reg != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      op1_reg       <= '0;
      op2_reg       <= '0;
      ctrl_reg      <= '0;
      rsp_valid_reg <= '0;
      result_reg    <= '0;
      overflow_reg  <= 1'b0;
      zf_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            op1_reg   <= op1_arr[pick_idx];
            op2_reg   <= op2_arr[pick_idx];
            ctrl_reg  <= ctrl_arr[pick_idx];
            owner_reg <= pick_idx;
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_reg    <= alu_out.result;
          overflow_reg  <= alu_out.overflow;
          zf_reg        <= alu_out.zf;
          rsp_valid_reg <= N_REQ'(1) << owner_reg;
          state_reg     <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready[owner_reg]) begin
            rsp_valid_reg <= '0;
            rr_ptr_reg    <= ptr_after_owner;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
